// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide engine owning the HI/LO register pair
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // MUL: {partial product high, remaining multiplier bits}; DIV: {remainder, dividend/quotient bits}
  logic [2*WIDTH-1:0] prod;
  // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   dvs;
  logic [2:0]         op_q;
  logic               neg_q;
  logic               neg_r;
  logic               is_signed;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  logic               ge;
  logic [WIDTH-1:0]   sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] mul_res;
  logic [2*WIDTH-1:0] mul_fin;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] div_fin;
  logic [2*WIDTH-1:0] fin;
  // operand magnitudes, one iteration step, and the sign-corrected commit value
  always_comb begin
    is_signed = (Op == OP_MULT) | (Op == OP_DIV) | (Op == OP_MADD) | (Op == OP_MSUB);
    neg_a     = is_signed & A[WIDTH-1];
    neg_b     = is_signed & B[WIDTH-1];
    mag_a     = neg_a ? -A : A;
    mag_b     = neg_b ? -B : B;
    msum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});
    mul_next  = {msum, prod[WIDTH-1:1]};
    ge        = prod[2*WIDTH-1:WIDTH-1] >= {1'b0, dvs};
    sub       = prod[2*WIDTH-2:WIDTH-1] - dvs;
    div_next  = {ge ? sub : prod[2*WIDTH-2:WIDTH-1], prod[WIDTH-2:0], ge};
    prod_next = (state == DIV) ? div_next : mul_next;
    mul_res   = neg_q ? -mul_next : mul_next;
    mul_fin   = (op_q == OP_MADD) ? {HI, LO} + mul_res :
                (op_q == OP_MSUB) ? {HI, LO} - mul_res : mul_res;
    quo       = div_next[WIDTH-1:0];
    rem       = div_next[2*WIDTH-1:WIDTH];
    div_fin   = {neg_r ? -rem : rem, neg_q ? -quo : quo};
    fin       = (state == DIV) ? div_fin : mul_fin;
  end
  // control FSM: accept, iterate one bit per cycle, commit HI/LO with a Done pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      dvs   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          op_q  <= Op;
          cnt   <= CNT_W'(WIDTH);
          neg_q <= neg_a ^ neg_b;
          neg_r <= neg_a;
          Busy  <= 1'b1;
          if (Op == OP_MTHI || Op == OP_MTLO) begin
            if (Op == OP_MTHI) HI <= A;
            else LO <= A;
            Done  <= 1'b1;
            state <= FIN;
          end else if (Op == OP_DIV || Op == OP_DIVU) begin
            // a zero divisor yields an all-ones quotient, which must not be negated
            prod  <= {{WIDTH{1'b0}}, mag_a};
            dvs   <= mag_b;
            neg_q <= (neg_a ^ neg_b) & (|B);
            state <= DIV;
          end else begin
            prod  <= {{WIDTH{1'b0}}, mag_b};
            dvs   <= mag_a;
            state <= MUL;
          end
        end
        MUL, DIV: begin
          prod <= prod_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            {HI, LO} <= fin;
            Done     <= 1'b1;
            state    <= FIN;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for the multiply/divide unit
module tb_mul_div_unit;
  localparam int W = 32;
  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  int           checks = 0;
  int           errors = 0;
  logic [63:0]  sb_q[$];
  logic [31:0]  m_hi = '0;
  logic [31:0]  m_lo = '0;

  always #5 Clk = ~Clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    logic [63:0] hl;
    int          q;
    int          r;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    hl = {hi, lo};
    case (op)
      3'd0: return 64'(sp);
      3'd1: return up;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd4: return hl + 64'(sp);
      3'd5: return hl - 64'(sp);
      3'd6: return {a, lo};
      default: return {hi, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive a request at a negedge; returns just after the accept edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = model(op, a, b, m_hi, m_lo);
    sb_q.push_back(e);
    {m_hi, m_lo} = e;
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(posedge Clk);
  endtask

  // count cycles to Done, compare against scoreboard; optional busy-poke and mid-op reset
  task automatic finish_op(input string tag, input int exp_cyc, input int poke_cyc, input int rst_cyc);
    int          cyc;
    bit          seen;
    logic [63:0] e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        Start = 1'b0;
        chk({tag, "_busy1"}, 64'(Busy), 64'd1);
      end
      if (cyc == poke_cyc) begin
        Start = 1'b1;
        Op    = 3'd2;
        A     = $urandom;
        B     = 32'd3;
      end
      if (cyc == poke_cyc + 1) Start = 1'b0;
      if (cyc == rst_cyc) begin
        Reset = 1'b1;
        @(negedge Clk);
        chk({tag, "_rst_hilo"}, {HI, LO}, 64'd0);
        chk({tag, "_rst_ctl"}, 64'({Busy, Done}), 64'd0);
        Reset = 1'b0;
        sb_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge Clk);
        chk({tag, "_rst_nodone"}, 64'(Done), 64'd0);
        return;
      end
      if (Done) seen = 1'b1;
    end
    chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'bx;
    if (seen) begin
      chk({tag, "_hilo"}, {HI, LO}, e);
      chk({tag, "_busy_done"}, 64'(Busy), 64'd1);
      @(negedge Clk);
      chk({tag, "_idle"}, 64'({Busy, Done}), 64'd0);
    end
  endtask

  initial begin
    int          n;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    Reset = 1'b1;
    Start = 1'b0;
    Op    = '0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_hilo", {HI, LO}, 64'd0);
    chk("reset_ctl", 64'({Busy, Done}), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    finish_op("mult", 33, 0, 0);
    chk("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    finish_op("multu", 33, 0, 0);
    chk("multu_const", {HI, LO}, 64'h00000001_FFFFFFFE);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    finish_op("div", 33, 0, 0);
    chk("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'd3, 32'd5, 32'd0);
    finish_op("divu_zero", 33, 0, 0);
    chk("divu_zero_const", {HI, LO}, 64'h00000005_FFFFFFFF);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    finish_op("div_ovf", 33, 0, 0);
    chk("div_ovf_const", {HI, LO}, 64'h00000000_80000000);
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    finish_op("div_negb", 33, 0, 0);
    issue(3'd6, 32'd0, 32'd0);
    finish_op("mthi", 1, 0, 0);
    issue(3'd7, 32'hFFFFFFFF, 32'd0);
    finish_op("mtlo", 1, 0, 0);
    chk("mtlo_const", {HI, LO}, 64'h00000000_FFFFFFFF);
    issue(3'd4, 32'd1, 32'd1);
    finish_op("madd", 33, 0, 0);
    chk("madd_const", {HI, LO}, 64'h00000001_00000000);
    issue(3'd5, 32'd2, 32'd3);
    finish_op("msub", 33, 0, 0);
    chk("msub_const", {HI, LO}, 64'h00000000_FFFFFFFA);
    issue(3'd0, 32'h12345678, 32'hFFFFFFFE);
    finish_op("mult_poke", 33, 5, 0);
    n = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) n++;
    end
    chk("poke_nodone", 64'(n), 64'd0);
    issue(3'd3, 32'd100, 32'd7);
    finish_op("divu_rst", 33, 0, 10);
    issue(3'd1, 32'hDEADBEEF, 32'h00010001);
    finish_op("after_rst", 33, 0, 0);
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(op, a, b);
      finish_op("rand", (op >= 3'd6) ? 1 : 33, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
